// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the environment (pipeline + memory) view.
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic              i_req;
  logic [XLEN-1:0]   i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [XLEN-1:0]   i_rdata;

  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;

  logic              m_req;
  logic              m_we;
  logic [XLEN-1:0]   m_addr;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN/8-1:0] m_wstrb;
  logic [XLEN-1:0]   m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between fetch (I) and load/store (D).
// D wins contention unless I has lost STARVE_MAX times in a row; one access in flight at a time.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int         SW         = XLEN / 8;
  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_lat_cnt;
  logic [2:0]      w_lat_next;
  logic [3:0]      r_starve_cnt;
  logic [3:0]      w_starve_next;
  logic            r_owner_d;
  logic            w_owner_next;
  logic            r_i_rvalid;
  logic            r_d_rvalid;
  logic            r_busy;

  logic            w_i_gnt;
  logic            w_d_gnt;
  logic            w_m_req;
  logic            w_m_we;
  logic [XLEN-1:0] w_m_addr;
  logic [XLEN-1:0] w_m_wdata;
  logic [SW-1:0]   w_m_wstrb;
  logic            w_d_wins;

  // Next-state, arbitration and memory command decode.
  always_comb begin
    w_state_next  = r_state;
    w_lat_next    = r_lat_cnt;
    w_starve_next = r_starve_cnt;
    w_owner_next  = r_owner_d;
    w_i_gnt       = 1'b0;
    w_d_gnt       = 1'b0;
    w_m_req       = 1'b0;
    w_m_we        = 1'b0;
    w_m_addr      = {XLEN{1'b0}};
    w_m_wdata     = {XLEN{1'b0}};
    w_m_wstrb     = {SW{1'b0}};
    w_d_wins      = bus.d_req && !(bus.i_req && (r_starve_cnt == STARVE_LIM));

    if (reset) begin
      w_state_next  = S_IDLE;
      w_lat_next    = 3'd0;
      w_starve_next = 4'd0;
      w_owner_next  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_d_wins) begin
            w_d_gnt      = 1'b1;
            w_m_req      = 1'b1;
            w_m_we       = bus.d_we;
            w_m_addr     = bus.d_addr;
            w_m_wdata    = bus.d_wdata;
            w_m_wstrb    = bus.d_wstrb;
            w_state_next = S_WAIT;
            w_lat_next   = LAT_LOAD;
            w_owner_next = 1'b1;
            // Only a loss suffered by a waiting fetch counts towards starvation.
            if (bus.i_req) begin
              if (r_starve_cnt >= STARVE_LIM) begin
                w_starve_next = STARVE_LIM;
              end else begin
                w_starve_next = r_starve_cnt + 4'd1;
              end
            end else begin
              w_starve_next = r_starve_cnt;
            end
          end else if (bus.i_req) begin
            w_i_gnt       = 1'b1;
            w_m_req       = 1'b1;
            w_m_addr      = bus.i_addr;
            w_state_next  = S_WAIT;
            w_lat_next    = LAT_LOAD;
            w_owner_next  = 1'b0;
            w_starve_next = 4'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt <= 3'd1) begin
            w_state_next = S_IDLE;
            w_lat_next   = 3'd0;
          end else begin
            w_state_next = S_WAIT;
            w_lat_next   = r_lat_cnt - 3'd1;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_lat_next   = 3'd0;
        end
      endcase
    end
  end

  // State, counters and the registered response/busy flags.
  // rvalid is set on the edge that brings lat_cnt to 1, so it is high exactly while lat_cnt == 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 4'd0;
      r_owner_d    <= 1'b0;
      r_i_rvalid   <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lat_cnt    <= w_lat_next;
      r_starve_cnt <= w_starve_next;
      r_owner_d    <= w_owner_next;
      r_i_rvalid   <= (w_state_next == S_WAIT) && (w_lat_next == 3'd1) && !w_owner_next;
      r_d_rvalid   <= (w_state_next == S_WAIT) && (w_lat_next == 3'd1) &&  w_owner_next;
      r_busy       <= (w_state_next == S_WAIT);
    end
  end

  assign bus.i_gnt    = w_i_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.m_req    = w_m_req;
  assign bus.m_we     = w_m_we;
  assign bus.m_addr   = w_m_addr;
  assign bus.m_wdata  = w_m_wdata;
  assign bus.m_wstrb  = w_m_wstrb;
  assign bus.i_rvalid = r_i_rvalid;
  assign bus.d_rvalid = r_d_rvalid;
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
  assign busy         = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// compared cycle by cycle against a timeline-based reference model and a memory macro model.
module tb_mem_port_arbiter;

  localparam int XLEN       = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int SW         = XLEN / 8;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic mem_load;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus();

  mem_port_arbiter #(
    .XLEN      (XLEN),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory macro: writes on the command edge, read data emerges MEM_LAT cycles after the command.
  logic [31:0] mac_mem [0:255];
  logic [31:0] rd_pipe [0:MEM_LAT-1];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mac_mem[i] <= init_word(i);
    end else if (bus.m_req && bus.m_we) begin
      for (int b = 0; b < SW; b++)
        if (bus.m_wstrb[b]) mac_mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
    end
    rd_pipe[0] <= (bus.m_req && !bus.m_we) ? mac_mem[bus.m_addr[9:2]] : 32'hBAD0_BAD0;
    for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign bus.m_rdata = rd_pipe[MEM_LAT-1];

  // Reference model state: a timeline of when the current access answers and when the port frees up.
  logic [31:0] ref_mem [0:255];
  int          cyc;
  int          free_at;
  int          rv_at;
  int          busy_lo;
  int          busy_hi;
  int          losses;
  logic        rv_is_d;
  logic        rv_is_store;
  logic [31:0] rv_data;
  logic        seen_i_gnt;
  logic        seen_d_gnt;
  bit          auto_i;
  bit          auto_d;
  int          checks;
  int          errors;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic run_cycle();
    logic        e_ig;
    logic        e_dg;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        win_d;
    @(negedge clk);
    e_ig = 1'b0; e_dg = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
    if (reset) begin
      losses  = 0;
      free_at = cyc + 1;
      if (rv_at > cyc)   rv_at   = -1;
      if (busy_hi > cyc) busy_hi = cyc;
    end else if (cyc >= free_at && (bus.i_req || bus.d_req)) begin
      win_d = bus.d_req && !(bus.i_req && losses == STARVE_MAX);
      if (win_d) begin
        e_dg = 1'b1; e_mreq = 1'b1; e_mwe = bus.d_we;
        e_addr = bus.d_addr; e_wdata = bus.d_wdata; e_wstrb = bus.d_wstrb;
        if (bus.i_req && losses < STARVE_MAX) losses++;
        rv_is_d = 1'b1;
        rv_is_store = bus.d_we;
        if (bus.d_we) begin
          for (int b = 0; b < SW; b++)
            if (bus.d_wstrb[b]) ref_mem[bus.d_addr[9:2]][8*b +: 8] = bus.d_wdata[8*b +: 8];
        end else begin
          rv_data = ref_mem[bus.d_addr[9:2]];
        end
      end else begin
        e_ig = 1'b1; e_mreq = 1'b1; e_addr = bus.i_addr;
        losses = 0;
        rv_is_d = 1'b0;
        rv_is_store = 1'b0;
        rv_data = ref_mem[bus.i_addr[9:2]];
      end
      rv_at   = cyc + MEM_LAT;
      busy_lo = cyc + 1;
      busy_hi = cyc + MEM_LAT;
      free_at = cyc + MEM_LAT + 1;
    end
    check_value("i_gnt",   32'(bus.i_gnt),   32'(e_ig));
    check_value("d_gnt",   32'(bus.d_gnt),   32'(e_dg));
    check_value("m_req",   32'(bus.m_req),   32'(e_mreq));
    check_value("m_we",    32'(bus.m_we),    32'(e_mwe));
    check_value("m_addr",  bus.m_addr,       e_addr);
    check_value("m_wdata", bus.m_wdata,      e_wdata);
    check_value("m_wstrb", 32'(bus.m_wstrb), 32'(e_wstrb));
    if (!reset) begin
      check_value("i_rvalid", 32'(bus.i_rvalid), 32'(rv_at == cyc && !rv_is_d));
      check_value("d_rvalid", 32'(bus.d_rvalid), 32'(rv_at == cyc && rv_is_d));
      check_value("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      if (rv_at == cyc && !rv_is_store) begin
        if (rv_is_d) check_value("d_rdata", bus.d_rdata, rv_data);
        else         check_value("i_rdata", bus.i_rdata, rv_data);
      end
    end
    seen_i_gnt = bus.i_gnt;
    seen_d_gnt = bus.d_gnt;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_i && seen_i_gnt) bus.i_req = 1'b0;
    if (auto_d && seen_d_gnt) bus.d_req = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    free_at = 0; rv_at = -1; busy_lo = 0; busy_hi = -1; losses = 0;
    rv_is_d = 1'b0; rv_is_store = 1'b0; rv_data = 32'h0;
    auto_i = 1'b1; auto_d = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset = 1'b1; mem_load = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0100;
    bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'hF;

    // Reset outranks requests on both ports.
    run_cycle();
    mem_load = 1'b0;
    run_cycle();
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    run_cycle();
    reset = 1'b0;
    run_cycles(2);

    // Single fetch.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
    run_cycles(4);

    // Contention: D first, fetch right after D's response.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0044;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100;
    run_cycles(8);

    // Starvation: both held, expect D,D,D,D,I repeating.
    auto_i = 1'b0; auto_d = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0008;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0010;
    run_cycles(31);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    run_cycles(3);
    auto_i = 1'b1; auto_d = 1'b1;

    // Partial store then fetch of the same word.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0200;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b0011;
    run_cycles(3);
    bus.d_we = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0200;
    run_cycles(4);

    // Reset one cycle after a fetch grant discards the response.
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080;
    run_cycle();
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    run_cycles(3);

    // Reset mid-transaction clears the starvation history.
    auto_i = 1'b0; auto_d = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_00C0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0140;
    run_cycles(7);
    reset = 1'b1;
    run_cycle();
    reset = 1'b0;
    run_cycles(16);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    run_cycles(3);
    auto_i = 1'b1; auto_d = 1'b1;

    // Fetch request raised during WAIT and withdrawn before IDLE.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0020;
    run_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_0024;
    run_cycle();
    bus.i_req = 1'b0;
    run_cycles(3);

    // Random traffic with occasional withdrawals and resets.
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!bus.i_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.i_req = 1'b1; bus.i_addr = $urandom();
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bus.i_req = 1'b0;
      end
      if (!bus.d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
          bus.d_addr = $urandom(); bus.d_wdata = $urandom(); bus.d_wstrb = 4'($urandom());
        end
      end else if ($urandom_range(0, 15) == 0) begin
        bus.d_req = 1'b0;
      end
      run_cycle();
    end
    reset = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    run_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
